vscale_xvec_lsu: RTL and testbench

VSCALE_XVEC_LSU -- requirements
Module: vscale_xvec_lsu

---
 rtl/vscale_xvec_lsu_pkg.sv | 22 ++
 rtl/vscale_xvec_lsu_agen.sv | 40 ++++
 rtl/vscale_xvec_lsu.sv | 155 +++++++++++++++
 tb/tb_vscale_xvec_lsu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_xvec_lsu_pkg.sv
// Shared xvec definitions for the vector load/store unit.
// Holds the default lane count and lane width, the address width,
// the LSU state encoding and a small address-alignment helper.
package vscale_xvec_lsu_pkg;

    localparam int XVEC_N_LANES = 32;
    localparam int XVEC_XPR_LEN = 32;
    localparam int XVEC_ADDR_W  = 32;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ADDR = 2'd1,
        LSU_DATA = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Lane accesses are whole words, so the base must be word aligned.
    function automatic logic addr_misaligned(input logic [XVEC_ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/vscale_xvec_lsu_agen.sv
// Lane-index counter and word address generator for the vector LSU.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   base         : byte base address of lane 0
//   clear        : restart at lane 0
//   step         : advance to the next lane
//   idx          : current lane index
//   addr         : base + 4*idx, wrapping modulo 2^32
//   last         : current lane is the final lane
module vscale_xvec_lsu_agen
    import vscale_xvec_lsu_pkg::*;
#(
    parameter int N_LANES = XVEC_N_LANES,
    parameter int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [XVEC_ADDR_W-1:0] base,
    input  logic                   clear,
    input  logic                   step,
    output logic [IDX_W-1:0]       idx,
    output logic [XVEC_ADDR_W-1:0] addr,
    output logic                   last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (step) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Plain 32-bit add: carries out of bit 31 are dropped, giving the wrap.
    assign addr = base + {{(XVEC_ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
    assign last = (idx == IDX_W'(N_LANES - 1));

endmodule

// File: rtl/vscale_xvec_lsu.sv
// Vector load/store unit: turns one N_LANES-wide vector access into
// N_LANES word accesses on a two-phase (address/data) memory port.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_store, req_addr   : direction and byte base address of lane 0
//   req_wdata             : packed store vector, lane i at [i*XPR_LEN +: XPR_LEN]
//   resp_valid, resp_err  : one-cycle completion pulse and its error flag
//   resp_rdata            : packed load vector, persists between loads
//   dmem_en/wen/addr      : memory address phase
//   dmem_wdata            : store word, driven in the data phase
//   dmem_rdata            : load word, returned in the data phase
//   dmem_wait             : data-phase stall
//   dmem_badmem_e         : data-phase access fault
module vscale_xvec_lsu
    import vscale_xvec_lsu_pkg::*;
#(
    parameter int N_LANES = XVEC_N_LANES,
    parameter int XPR_LEN = XVEC_XPR_LEN
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic [XVEC_ADDR_W-1:0]       req_addr,
    input  logic [N_LANES*XPR_LEN-1:0]   req_wdata,
    output logic                         resp_valid,
    output logic                         resp_err,
    output logic [N_LANES*XPR_LEN-1:0]   resp_rdata,
    output logic                         dmem_en,
    output logic                         dmem_wen,
    output logic [XVEC_ADDR_W-1:0]       dmem_addr,
    output logic [XPR_LEN-1:0]           dmem_wdata,
    input  logic [XPR_LEN-1:0]           dmem_rdata,
    input  logic                         dmem_wait,
    input  logic                         dmem_badmem_e
);

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int VEC_W = N_LANES * XPR_LEN;

    lsu_state_e             state;
    logic                   store_q;
    logic [XVEC_ADDR_W-1:0] base_q;
    logic [VEC_W-1:0]       wdata_q;

    logic                   accept;
    logic                   beat_ok;
    logic [IDX_W-1:0]       idx;
    logic [XVEC_ADDR_W-1:0] lane_addr;
    logic                   last;

    assign req_ready = (state == LSU_IDLE);
    assign accept    = req_valid && req_ready;
    // A data phase that completes without stall or fault.
    assign beat_ok   = (state == LSU_DATA) && !dmem_wait && !dmem_badmem_e;

    vscale_xvec_lsu_agen #(
        .N_LANES (N_LANES),
        .IDX_W   (IDX_W)
    ) u_agen (
        .clk     (clk),
        .reset_n (reset_n),
        .base    (base_q),
        .clear   (accept),
        .step    (beat_ok && !last),
        .idx     (idx),
        .addr    (lane_addr),
        .last    (last)
    );

    // Request capture: pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            store_q <= req_store;
            base_q  <= req_addr;
            if (req_store) begin
                wdata_q <= req_wdata;
            end
        end
    end

    // Control FSM with registered memory-enable and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LSU_IDLE;
            dmem_en    <= 1'b0;
            dmem_wen   <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        if (addr_misaligned(req_addr)) begin
                            state      <= LSU_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state    <= LSU_ADDR;
                            dmem_en  <= 1'b1;
                            dmem_wen <= req_store;
                        end
                    end
                end
                LSU_ADDR: begin
                    state    <= LSU_DATA;
                    dmem_en  <= 1'b0;
                    dmem_wen <= 1'b0;
                end
                LSU_DATA: begin
                    if (!dmem_wait) begin
                        if (dmem_badmem_e) begin
                            state      <= LSU_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (last) begin
                            state      <= LSU_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                        end else begin
                            state    <= LSU_ADDR;
                            dmem_en  <= 1'b1;
                            dmem_wen <= store_q;
                        end
                    end
                end
                LSU_DONE: begin
                    state      <= LSU_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

    // Load results land lane by lane; a fault leaves unwritten lanes as they were.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_rdata <= '0;
        end else if (beat_ok && !store_q) begin
            resp_rdata[idx*XPR_LEN +: XPR_LEN] <= dmem_rdata;
        end
    end

    // Address and store data are gated by state so they read as zero when idle
    // or in reset, without resetting the captured request registers.
    assign dmem_addr  = ((state == LSU_ADDR) || (state == LSU_DATA)) ? lane_addr : '0;
    assign dmem_wdata = (state == LSU_DATA) ? wdata_q[idx*XPR_LEN +: XPR_LEN] : '0;

endmodule

// File: tb/tb_vscale_xvec_lsu.sv
// Directed bench for vscale_xvec_lsu with a small word-addressed memory model.
module tb_vscale_xvec_lsu;

    localparam int NL = 32;
    localparam int XL = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [NL*XL-1:0]  req_wdata = '0;
    logic              resp_valid;
    logic              resp_err;
    logic [NL*XL-1:0]  resp_rdata;
    logic              dmem_en;
    logic              dmem_wen;
    logic [31:0]       dmem_addr;
    logic [XL-1:0]     dmem_wdata;
    logic [XL-1:0]     dmem_rdata = '0;
    logic              dmem_wait = 1'b0;
    logic              dmem_badmem_e = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_vec [NL];
    logic [31:0] phase_addr [64];

    vscale_xvec_lsu #(
        .N_LANES (NL),
        .XPR_LEN (XL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .resp_rdata    (resp_rdata),
        .dmem_en       (dmem_en),
        .dmem_wen      (dmem_wen),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_wait     (dmem_wait),
        .dmem_badmem_e (dmem_badmem_e)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Memory contents: the word at 0x100+4k holds 0xA0000000+k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + ((a - 32'h100) >> 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("%s_lane%0d", tag, i), resp_rdata[i*XL +: XL], exp_vec[i]);
        end
    endtask

    // Runs one request to completion. Latency counts the accepting edge as 1.
    task automatic run_req(input string tag, input logic st, input logic [31:0] a,
                           input int wait_lane, input int wait_n, input int bad_lane,
                           output int lat, output int phases, output logic err);
        int          stall_left;
        int          cur_lane;
        logic [31:0] cur_addr;
        logic        in_data;
        logic        got;
        stall_left = wait_n;
        cur_lane   = 0;
        cur_addr   = 32'h0;
        in_data    = 1'b0;
        got        = 1'b0;
        lat        = 0;
        phases     = 0;
        err        = 1'b0;
        req_valid  = 1'b1;
        req_store  = st;
        req_addr   = a;
        tick();
        req_valid  = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (resp_valid) begin
                got = 1'b1;
                lat = k + 1;
                err = resp_err;
                break;
            end
            dmem_wait     = 1'b0;
            dmem_badmem_e = 1'b0;
            if (dmem_en) begin
                chk({tag, "_addr"}, dmem_addr, a + 32'(phases) * 32'd4);
                chk({tag, "_wen"}, 32'(dmem_wen), 32'(st));
                if (phases < 64) phase_addr[phases] = dmem_addr;
                cur_lane = phases;
                cur_addr = dmem_addr;
                phases++;
                in_data = 1'b1;
            end else if (in_data) begin
                chk({tag, "_data_addr_hold"}, dmem_addr, cur_addr);
                if (st) chk({tag, "_wdata"}, dmem_wdata, 32'(cur_lane) * 32'h0101_0101);
                dmem_rdata = mem_word(cur_addr);
                if (cur_lane == wait_lane && stall_left > 0) begin
                    dmem_wait = 1'b1;
                    stall_left--;
                end else begin
                    in_data = 1'b0;
                    dmem_badmem_e = (cur_lane == bad_lane);
                end
            end
            tick();
        end
        dmem_wait     = 1'b0;
        dmem_badmem_e = 1'b0;
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
        tick();
        chk({tag, "_resp_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   lat;
        int   ph;
        logic err;
        logic found;

        // Reset values
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_en", 32'(dmem_en), 32'd0);
        chk("rst_wen", 32'(dmem_wen), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata_lo", resp_rdata[31:0], 32'd0);
        reset_n = 1'b1;
        tick();

        // Zero-wait load at 0x100
        run_req("ld100", 1'b0, 32'h100, -1, 0, -1, lat, ph, err);
        chk("ld100_lat", 32'(lat), 32'd65);
        chk("ld100_phases", 32'(ph), 32'd32);
        chk("ld100_err", 32'(err), 32'd0);
        chk("ld100_last_addr", phase_addr[31], 32'h17C);
        for (int k = 0; k < NL; k++) exp_vec[k] = 32'hA000_0000 + 32'(k);
        chk_lanes("ld100");

        // Store at 0x200, lane k = k*0x01010101; load data must survive
        for (int k = 0; k < NL; k++) req_wdata[k*XL +: XL] = 32'(k) * 32'h0101_0101;
        run_req("st200", 1'b1, 32'h200, -1, 0, -1, lat, ph, err);
        chk("st200_lat", 32'(lat), 32'd65);
        chk("st200_phases", 32'(ph), 32'd32);
        chk("st200_err", 32'(err), 32'd0);
        chk_lanes("st200_rdata_kept");

        // Load at 0x400 with three stall cycles on lane 5
        run_req("ldwait", 1'b0, 32'h400, 5, 3, -1, lat, ph, err);
        chk("ldwait_lat", 32'(lat), 32'd68);
        chk("ldwait_err", 32'(err), 32'd0);
        for (int k = 0; k < NL; k++) exp_vec[k] = 32'hA000_00C0 + 32'(k);
        chk_lanes("ldwait");

        // Load at 0x100 faulting on lane 10: lanes 0..9 new, rest keep 0x400 data
        run_req("ldbad", 1'b0, 32'h100, -1, 0, 10, lat, ph, err);
        chk("ldbad_err", 32'(err), 32'd1);
        chk("ldbad_phases", 32'(ph), 32'd11);
        chk("ldbad_lat", 32'(lat), 32'd23);
        for (int k = 0; k < 10; k++) exp_vec[k] = 32'hA000_0000 + 32'(k);
        chk_lanes("ldbad");

        // Misaligned base: error response straight after acceptance, no access
        run_req("mis102", 1'b0, 32'h102, -1, 0, -1, lat, ph, err);
        chk("mis102_err", 32'(err), 32'd1);
        chk("mis102_phases", 32'(ph), 32'd0);
        chk("mis102_lat", 32'(lat), 32'd1);
        chk_lanes("mis102_rdata_kept");

        // Base near the top of the address space wraps to zero
        run_req("ldwrap", 1'b0, 32'hFFFF_FFF0, -1, 0, -1, lat, ph, err);
        chk("ldwrap_err", 32'(err), 32'd0);
        chk("ldwrap_phases", 32'(ph), 32'd32);
        chk("ldwrap_addr3", phase_addr[3], 32'hFFFF_FFFC);
        chk("ldwrap_addr4", phase_addr[4], 32'h0000_0000);
        chk("ldwrap_lane0", resp_rdata[0*XL +: XL], 32'hDFFF_FFBC);
        chk("ldwrap_lane4", resp_rdata[4*XL +: XL], 32'hDFFF_FFC0);

        // Reset during lane 7 of a store
        req_valid = 1'b1;
        req_store = 1'b1;
        req_addr  = 32'h200;
        tick();
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dmem_en && dmem_addr == 32'h21C) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rstmid_reach_lane7", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_en", 32'(dmem_en), 32'd0);
        chk("rstmid_wen", 32'(dmem_wen), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_addr", dmem_addr, 32'd0);
        chk("rstmid_wdata", dmem_wdata, 32'd0);
        chk("rstmid_rdata_lane0", resp_rdata[0*XL +: XL], 32'd0);
        chk("rstmid_rdata_lane31", resp_rdata[31*XL +: XL], 32'd0);
        tick();
        chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
        reset_n = 1'b1;
        run_req("ldpost", 1'b0, 32'h100, -1, 0, -1, lat, ph, err);
        chk("ldpost_lat", 32'(lat), 32'd65);
        chk("ldpost_err", 32'(err), 32'd0);
        for (int k = 0; k < NL; k++) exp_vec[k] = 32'hA000_0000 + 32'(k);
        chk_lanes("ldpost");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
